// File: rtl/joypad_serial_ctrl.sv
// SFC joypad serial reader: latch/clock sequencing, 16-bit shift-in, 12-button decode, dimming PWM.
// Optional JOYPAD_DEBOUNCE_EN: publish a read only when it matches the previous raw read.
module joypad_serial_ctrl #(
    parameter int HALF_PERIOD   = 64,
    parameter int POLL_INTERVAL = 357954,
    parameter int PWM_PRESCALE  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  dim_level,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [11:0] joypad,
    output logic        connected,
    output logic        valid,
    output logic        busy,
    output logic        no_push_pwm
);

    localparam int PH_W   = $clog2(2 * HALF_PERIOD);
    localparam int POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     ph_cnt_q, ph_cnt_d;
    logic [3:0]          bit_q, bit_d;
    logic                hi_q, hi_d;
    logic [15:0]         sr_q, sr_d;
    logic                sync1_q, sync2_q;
    logic [POLL_W-1:0]   poll_cnt_q;
    logic                poll_wrap;
    logic                pending_q, pending_d, pending_clr;
    logic                done;
    logic                accept;
    logic                new_conn;
    logic [11:0]         new_joy;
    logic [11:0]         joypad_q;
    logic                connected_q, valid_q;
    logic [PRE_W-1:0]    pre_q;
    logic [3:0]          pwm_cnt_q;
    logic                pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pad_data;
            sync2_q <= sync1_q;
        end
    end

    assign poll_wrap = (poll_cnt_q == POLL_W'(POLL_INTERVAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt_q <= '0;
        end else if (poll_wrap) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
        end
    end

    // A new request wins over a same-cycle clear so no request is ever dropped.
    always_comb begin
        pending_d = pending_q;
        if (start || poll_wrap) begin
            pending_d = 1'b1;
        end else if (pending_clr) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ph_cnt_q  <= '0;
            bit_q     <= '0;
            hi_q      <= 1'b0;
            sr_q      <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_cnt_q  <= ph_cnt_d;
            bit_q     <= bit_d;
            hi_q      <= hi_d;
            sr_q      <= sr_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_cnt_d    = ph_cnt_q;
        bit_d       = bit_q;
        hi_d        = hi_q;
        sr_d        = sr_q;
        pending_clr = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d     = S_LATCH;
                    ph_cnt_d    = '0;
                    pending_clr = 1'b1;
                end
            end
            S_LATCH: begin
                if (ph_cnt_q == PH_W'(2 * HALF_PERIOD - 1)) begin
                    state_d  = S_SHIFT;
                    ph_cnt_d = '0;
                    bit_d    = '0;
                    hi_d     = 1'b1;
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (ph_cnt_q == PH_W'(HALF_PERIOD - 1)) begin
                    ph_cnt_d = '0;
                    if (hi_q) begin
                        // Sample at the end of the high phase; the pad drives active-low.
                        sr_d[bit_q] = ~sync2_q;
                        hi_d        = 1'b0;
                    end else if (bit_q == 4'd15) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        hi_d  = 1'b1;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pad_latch = (state_q == S_LATCH);
    assign pad_clk   = !((state_q == S_SHIFT) && !hi_q);
    assign busy      = (state_q != S_IDLE);

    // Pad bit 0 (B) lands on joypad[11]; a nonzero ID nibble means no standard pad.
    always_comb begin
        new_conn = (sr_q[15:12] == 4'b0000);
        new_joy  = '0;
        for (int i = 0; i < 12; i++) begin
            new_joy[11-i] = sr_q[i];
        end
        if (!new_conn) begin
            new_joy = '0;
        end
    end

`ifdef JOYPAD_DEBOUNCE_EN
    logic [15:0] raw_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= '0;
        end else if (done) begin
            raw_q <= sr_q;
        end
    end

    assign accept = done && (sr_q == raw_q);
`else
    assign accept = done;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            joypad_q    <= '0;
            connected_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                joypad_q    <= new_joy;
                connected_q <= new_conn;
            end
        end
    end

    assign joypad    = joypad_q;
    assign connected = connected_q;
    assign valid     = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            if (pre_q == PRE_W'(PWM_PRESCALE - 1)) begin
                pre_q     <= '0;
                pwm_cnt_q <= pwm_cnt_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            pwm_q <= (pwm_cnt_q < dim_level);
        end
    end

    assign no_push_pwm = pwm_q;

endmodule

// File: tb/tb_joypad_serial_ctrl.sv
// Self-checking bench for joypad_serial_ctrl: behavioural pad model, read scoreboard, poll/PWM/reset checks.
module tb_joypad_serial_ctrl;

  localparam int HP   = 4;
  localparam int POLL = 1000;
  localparam int PRE  = 2;
  localparam int W    = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  dim_level = 4'd0;
  logic        pad_data;
  logic        pad_latch, pad_clk, connected, valid, busy, no_push_pwm;
  logic [11:0] joypad;

  logic [15:0] pad_word = 16'hFFFF;
  int          pad_idx = 0;

  logic [W-1:0] exp_q[$];
  int           lat_t[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_valid = 0;
  logic         busy_prev = 1'b0;
  logic [15:0]  prev_raw = 16'h0000;

  joypad_serial_ctrl #(
    .HALF_PERIOD(HP),
    .POLL_INTERVAL(POLL),
    .PWM_PRESCALE(PRE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dim_level(dim_level),
    .pad_data(pad_data),
    .pad_latch(pad_latch),
    .pad_clk(pad_clk),
    .joypad(joypad),
    .connected(connected),
    .valid(valid),
    .busy(busy),
    .no_push_pwm(no_push_pwm)
  );

  // clock / reset
  always #5 clk = ~clk;

  // pad: latch presents bit 0, each later pad_clk rise advances one bit
  always @(posedge pad_latch) pad_idx = 0;
  always @(posedge pad_clk) if (!pad_latch && pad_idx < 15) pad_idx = pad_idx + 1;
  assign pad_data = pad_word[pad_idx];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] expect_of(input logic [15:0] wire_word);
    logic [15:0] sr;
    logic [11:0] joy;
    logic        conn;
    sr   = ~wire_word;
    conn = (sr[15:12] == 4'b0000);
    for (int i = 0; i < 12; i++) joy[11-i] = sr[i];
    if (!conn) joy = 12'h000;
    return {conn, joy};
  endfunction

  // scoreboard: one expectation per latch entry, popped on each valid
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (busy && !busy_prev) begin
        lat_t.push_back(cyc);
`ifdef JOYPAD_DEBOUNCE_EN
        if (~pad_word == prev_raw) exp_q.push_back(expect_of(pad_word));
        prev_raw = ~pad_word;
`else
        exp_q.push_back(expect_of(pad_word));
`endif
      end
      if (valid) begin
        n_valid++;
        if (exp_q.size() == 0) check("sb_unexpected_valid", 1, 0);
        else check("sb_result", {connected, joypad}, exp_q.pop_front());
      end
    end
    busy_prev = busy;
  end

  // driver tasks
  task automatic pulse_start();
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 500) begin @(posedge clk) #1; k++; end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic measure_read(output int latch_n, output int low_n, output int low_bad,
                              output int valid_at, output int busy_n);
    int   t, run;
    logic pc_prev;
    latch_n = 0; low_n = 0; low_bad = 0; valid_at = -1; busy_n = 0;
    t = 0;
    @(negedge clk);
    while (!busy && t < 50) begin @(negedge clk); t++; end
    if (!busy) check("busy_rise_timeout", 0, 1);
    pc_prev = 1'b1;
    run = 0;
    for (int i = 0; i < 200; i++) begin
      latch_n += int'(pad_latch);
      busy_n  += int'(busy);
      if (valid && valid_at < 0) valid_at = i;
      if (!pad_clk) run++;
      else if (!pc_prev) begin
        low_n++;
        if (run != HP) low_bad++;
        run = 0;
      end
      pc_prev = pad_clk;
      @(negedge clk);
    end
  endtask

  task automatic do_read(input logic [15:0] w, input logic timing_chk);
    int ln, lo, lb, va, bn;
    wait_idle();
    @(posedge clk) #1 pad_word = w;
    pulse_start();
    measure_read(ln, lo, lb, va, bn);
    if (timing_chk) begin
      check("latch_cycles", ln, 2 * HP);
      check("clk_low_pulses", lo, 16);
      check("clk_low_width_bad", lb, 0);
      check("busy_cycles", bn, 34 * HP + 1);
`ifndef JOYPAD_DEBOUNCE_EN
      check("valid_cycle", va, 34 * HP + 1);
`endif
    end
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hi += int'(no_push_pwm);
    end
  endtask

  initial begin
    int       n0, k, hi, nv;
    logic [15:0] w;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pad_latch", pad_latch, 0);
    check("rst_pad_clk", pad_clk, 1);
    check("rst_joypad", joypad, 0);
    check("rst_connected", connected, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pwm", no_push_pwm, 0);
    @(posedge clk) #1 rst_n = 1'b1;

    // B (bit 0) and A (bit 8) pressed, ID nibble high
    do_read(16'hFEFE, 1'b1);
`ifndef JOYPAD_DEBOUNCE_EN
    check("ba_joypad", joypad, 12'h808);
    check("ba_connected", connected, 1);
`endif

    // unplugged: everything reads pressed
    do_read(16'h0000, 1'b1);
`ifndef JOYPAD_DEBOUNCE_EN
    check("unplug_joypad", joypad, 12'h000);
    check("unplug_connected", connected, 0);
`endif

    for (int r = 0; r < 3; r++) begin
      w = 16'($urandom_range(0, 4095));
      w[15:12] = (r == 2) ? 4'b1110 : 4'b1111;
      do_read(w, 1'b0);
    end

    // automatic polling period, then merged start requests during a poll read
    n0 = lat_t.size();
    k = 0;
    while (lat_t.size() < n0 + 3 && k < 3500) begin @(negedge clk); k++; end
    check("poll_reads_seen", lat_t.size() >= n0 + 3, 1);
    if (lat_t.size() >= n0 + 3) begin
      check("poll_interval", lat_t[n0+2] - lat_t[n0+1], POLL);
      repeat (20) @(posedge clk);
      pulse_start();
      repeat (30) @(posedge clk);
      pulse_start();
      repeat (600) @(posedge clk);
      check("merged_read_count", lat_t.size(), n0 + 4);
      if (lat_t.size() >= n0 + 4)
        check("merged_read_start", lat_t[n0+3] - lat_t[n0+2], 34 * HP + 2);
    end

    // PWM duty
    @(posedge clk) #1 dim_level = 4'd4;
    repeat (2) @(posedge clk);
    count_pwm(64, hi);
    check("pwm_dim4", hi, 16);
    @(posedge clk) #1 dim_level = 4'd15;
    repeat (2) @(posedge clk);
    count_pwm(64, hi);
    check("pwm_dim15", hi, 60);
    @(posedge clk) #1 dim_level = 4'd0;
    repeat (2) @(posedge clk);
    count_pwm(64, hi);
    check("pwm_dim0", hi, 0);

    // reset during SHIFT bit 7
    wait_idle();
    @(posedge clk) #1 pad_word = 16'hFFF0;
    pulse_start();
    k = 0;
    while (!busy && k < 50) begin @(posedge clk) #1; k++; end
    check("abort_busy_rise", busy, 1);
    repeat (8 + 7 * 2 * HP + 2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_pad_clk", pad_clk, 1);
    check("abort_pad_latch", pad_latch, 0);
    check("abort_joypad", joypad, 0);
    check("abort_connected", connected, 0);
    exp_q.delete();
    prev_raw = 16'h0000;
    @(posedge clk) #1 rst_n = 1'b1;
    do_read(16'hF7BD, 1'b1);
`ifndef JOYPAD_DEBOUNCE_EN
    check("post_abort_joypad", joypad, 12'h421);
    check("post_abort_connected", connected, 1);
`else
    // debounce: a changed read is held back until it repeats
    w = 16'hF0F0;
    do_read(w, 1'b0);
    do_read(w, 1'b0);
    nv = n_valid;
    do_read(w ^ 16'h0010, 1'b0);
    check("deb_no_valid", n_valid - nv, 0);
    do_read(w ^ 16'h0010, 1'b0);
    check("deb_valid", n_valid - nv, 1);
    check("deb_joypad", joypad, expect_of(w ^ 16'h0010) & 13'h0FFF);
`endif

    wait_idle();
    repeat (4) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
